// File: rtl/ctrl_sequencer.sv
// Registered multi-cycle instruction sequencer: decodes one instruction per handshake,
// sequences LOD through a timed memory wait, owns the CMP status register. Optional JNE via BRANCH_NE_EN.
module ctrl_sequencer #(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 12,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        alu_flags_in,
    input  logic              mem_ack,
    output logic [3:0]        alu_op,
    output logic [3:0]        alu_src1,
    output logic [3:0]        alu_src2,
    output logic [3:0]        alu_dest,
    output logic              reg_write_enable,
    output logic              imm,
    output logic [DATA_W-1:0] imm_val,
    output logic              load_pc,
    output logic [PC_W-1:0]   load_pc_val,
    output logic              mem_rd,
    output logic              mem_data_in,
    output logic [3:0]        status_q,
    output logic              mem_err,
    output logic              busy
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_LUI = 4'h7;
    localparam logic [3:0] OP_LLI = 4'h8;
    localparam logic [3:0] OP_JNE = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_JEQ = 4'hB;
    localparam logic [3:0] OP_LOD = 4'hC;

    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MEM_WAIT = 2'd2,
        WB       = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]        alu_op;
        logic [3:0]        src1;
        logic [3:0]        src2;
        logic [3:0]        dest;
        logic              we;
        logic              imm;
        logic [DATA_W-1:0] imm_val;
        logic              load_pc;
        logic [PC_W-1:0]   pc_val;
        logic              mem_rd;
        logic              mem_data_in;
    } ctrl_t;

    state_t     state;
    ctrl_t      ctrl_q;
    logic [3:0] cur_op;
    logic [7:0] wait_cnt;
    logic [8:0] cnt_next;

    // Control word for the EXEC cycle; eq_flag is the status bit sampled when the instruction is accepted.
    function automatic ctrl_t decode(input logic [15:0] ins, input logic eq_flag);
        ctrl_t c;
        c = '0;
        case (ins[15:12])
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR: begin
                c.alu_op = ins[15:12];
                c.src1   = ins[11:8];
                c.src2   = ins[7:4];
                c.dest   = ins[3:0];
                c.we     = 1'b1;
            end
            OP_JMP: begin
                c.load_pc = 1'b1;
                c.pc_val  = PC_W'(ins[11:0]);
            end
            OP_LUI: begin
                c.dest    = ins[11:8];
                c.imm     = 1'b1;
                c.imm_val = {ins[7:0], {(DATA_W-8){1'b0}}};
                c.we      = 1'b1;
            end
            OP_LLI: begin
                c.alu_op  = OP_OR;
                c.src2    = ins[11:8];
                c.dest    = ins[11:8];
                c.imm     = 1'b1;
                c.imm_val = DATA_W'(ins[7:0]);
                c.we      = 1'b1;
            end
`ifdef BRANCH_NE_EN
            OP_JNE: begin
                c.load_pc = ~eq_flag;
                c.pc_val  = PC_W'(ins[11:0]);
            end
`endif
            OP_CMP: begin
                c.alu_op = OP_SUB;
                c.src1   = ins[11:8];
                c.src2   = ins[7:4];
            end
            OP_JEQ: begin
                c.load_pc = eq_flag;
                c.pc_val  = PC_W'(ins[11:0]);
            end
            OP_LOD: begin
                c.src1   = ins[7:4];
                c.dest   = ins[11:8];
                c.mem_rd = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign cnt_next = {1'b0, wait_cnt} + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ctrl_q   <= '0;
            cur_op   <= OP_NOP;
            wait_cnt <= '0;
            status_q <= '0;
            mem_err  <= 1'b0;
        end else begin
            // Every control is a pulse unless a state below explicitly holds it.
            ctrl_q <= '0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        state  <= EXEC;
                        cur_op <= instr[15:12];
                        ctrl_q <= decode(instr, status_q[0]);
                    end
                end
                EXEC: begin
                    if (cur_op == OP_CMP) begin
                        status_q <= alu_flags_in;
                    end
                    if (cur_op == OP_LOD) begin
                        state              <= MEM_WAIT;
                        wait_cnt           <= '0;
                        ctrl_q.mem_rd      <= 1'b1;
                        ctrl_q.mem_data_in <= 1'b1;
                        ctrl_q.src1        <= ctrl_q.src1;
                        ctrl_q.dest        <= ctrl_q.dest;
                    end else begin
                        state <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    // An ack arriving on the last allowed cycle still completes the load.
                    if (mem_ack) begin
                        state              <= WB;
                        wait_cnt           <= cnt_next[7:0];
                        ctrl_q.we          <= 1'b1;
                        ctrl_q.mem_data_in <= 1'b1;
                        ctrl_q.dest        <= ctrl_q.dest;
                    end else if (cnt_next >= TIMEOUT_LIM) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt           <= cnt_next[7:0];
                        ctrl_q.mem_rd      <= 1'b1;
                        ctrl_q.mem_data_in <= 1'b1;
                        ctrl_q.src1        <= ctrl_q.src1;
                        ctrl_q.dest        <= ctrl_q.dest;
                    end
                end
                WB: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign instr_ready      = (state == IDLE);
    assign busy             = (state != IDLE);
    assign alu_op           = ctrl_q.alu_op;
    assign alu_src1         = ctrl_q.src1;
    assign alu_src2         = ctrl_q.src2;
    assign alu_dest         = ctrl_q.dest;
    assign reg_write_enable = ctrl_q.we;
    assign imm              = ctrl_q.imm;
    assign imm_val          = ctrl_q.imm_val;
    assign load_pc          = ctrl_q.load_pc;
    assign load_pc_val      = ctrl_q.pc_val;
    assign mem_rd           = ctrl_q.mem_rd;
    assign mem_data_in      = ctrl_q.mem_data_in;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Registered, multi-cycle successor to the combinational instruction decoder.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and drives registered ALU, register-file, PC and memory control for one EXEC cycle.
- LOD is sequenced through a memory wait state with an ack and a timeout.
- Owns the status (flag) register that CMP writes and JEQ reads; data width and PC width are parametrised.

Parameters:
- DATA_W, 16, width of imm_val. Must be >= 16.
- PC_W, 12, width of load_pc_val. Must be >= 12. Jump targets are zero-extended from instr[11:0].
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort. Range 1..255.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- instr, input, 16, instruction. Opcode is instr[15:12].
- instr_valid, input, 1, instr is valid this cycle.
- instr_ready, output, 1, sequencer can accept an instruction.
- alu_flags_in, input, 4, ALU flags: bit0 = equal/zero, bits 3:1 spare.
- mem_ack, input, 1, memory read data is available.
- alu_op, output, 4, ALU operation code.
- alu_src1, output, 4, source register 1.
- alu_src2, output, 4, source register 2.
- alu_dest, output, 4, destination register.
- reg_write_enable, output, 1, register-file write strobe.
- imm, output, 1, select imm_val as the write/ALU operand.
- imm_val, output, DATA_W, immediate value.
- load_pc, output, 1, PC load strobe.
- load_pc_val, output, PC_W, PC target.
- mem_rd, output, 1, memory read request.
- mem_data_in, output, 1, select memory data for writeback.
- status_q, output, 4, status register.
- mem_err, output, 1, sticky memory timeout flag.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Synchronous active-high reset, single clock (clk, rst). Reset forces state=IDLE, all control outputs to 0, status_q=0, mem_err=0, wait counter=0.
- FSM states: IDLE, EXEC, MEM_WAIT, WB.
- IDLE: instr_ready=1.
  - instr_valid=1 in cycle T latches instr and moves to EXEC.
  - Decoded controls are registered and visible in T+1.
- EXEC: exactly one cycle; instr_ready=0.
  - ADD(1)/SUB(2)/MUL(3)/AND(4)/OR(5): alu_op=opcode, src1=instr[11:8], src2=instr[7:4], dest=instr[3:0], reg_write_enable=1.
  - JMP(6): load_pc=1, load_pc_val=zero-extended instr[11:0].
  - LUI(7): dest=instr[11:8], imm=1, imm_val=instr[7:0] in bits DATA_W-1:DATA_W-8, all other bits 0, reg_write_enable=1.
  - LLI(8): alu_op=OR, src2=dest=instr[11:8], imm=1, imm_val=zero-extended instr[7:0], reg_write_enable=1.
  - CMP(A): alu_op=SUB, src1=instr[11:8], src2=instr[7:4], no write. status_q <= alu_flags_in at the end of the EXEC cycle.
  - JEQ(B): load_pc=status_q[0], load_pc_val=zero-extended instr[11:0].
  - LOD(C): src1=instr[7:4], dest=instr[11:8], mem_rd=1. Next state is MEM_WAIT; all other opcodes return to IDLE.
  - NOP(0) and undefined opcodes (9, D, E, F): all controls 0, return to IDLE.
- MEM_WAIT:
  - Held: mem_rd=1, src1, dest, mem_data_in=1.
  - Counter increments each cycle.
  - mem_ack=1 moves to WB; mem_ack in the same cycle as a timeout wins over the timeout.
  - Counter reaching MEM_TIMEOUT without ack: mem_err<=1, all controls drop, return to IDLE, no writeback.
- WB: one cycle, reg_write_enable=1, mem_data_in=1, dest held, mem_rd=0. Then IDLE, counter cleared.
- All strobes (reg_write_enable, load_pc, mem_rd) are 0 in IDLE. Only the 1-cycle pulses and MEM_WAIT hold them.
- Throughput: 2 cycles per non-LOD instruction; LOD takes 3 + wait cycles.
- mem_err is cleared only by rst.
- rst mid-operation (any state) takes effect at the next edge: pending writeback and memory request are dropped, status_q is cleared.
- Outputs are registered; there is no combinational path from instr to the control outputs.

Optional Feature:
- Macro BRANCH_NE_EN.
- Defined: opcode 9 = JNE, load_pc=~status_q[0], load_pc_val=zero-extended instr[11:0].
- Undefined: opcode 9 decodes as NOP.

Test Plan:
- ADD: instr=0x1123, valid in T -> in T+1 alu_op=1, src1=1, src2=2, dest=3, reg_write_enable=1; T+2 all 0, instr_ready=1.
- Immediates at DATA_W=32: LUI 0x7A5C -> dest=0xA, imm_val=0x5C000000. LLI 0x8A3F -> imm_val=0x0000003F, alu_op=5, src2=dest=0xA.
- Branch on flags:
  - CMP 0xA120 with alu_flags_in=4'b0001, then JEQ 0xB0FF -> load_pc=1, load_pc_val=0x0FF.
  - Repeat with flags=0 -> load_pc=0.
- LOD with ack: 0xC340, mem_ack after 3 wait cycles -> mem_rd high 4 cycles, then 1-cycle reg_write_enable=1 with dest=3, mem_data_in=1.
- LOD without ack, MEM_TIMEOUT=4 -> mem_err=1 after 4 wait cycles, no reg_write_enable, back to IDLE. Assert rst in MEM_WAIT -> next cycle all outputs 0, mem_err=0.
- Undefined opcode 0xD123 -> no strobes. With BRANCH_NE_EN and status_q[0]=0, 0x9010 -> load_pc=1, load_pc_val=0x010.
